// File: rtl/load_buffer.sv
// In-order load buffer between the address unit and the memory controller.
// Issues one read at a time, extends the returned data and broadcasts it on the CDB lane.
module load_buffer #(
    parameter int                       LBDepth       = 8,
    parameter int                       LBWidth       = 3,
    parameter logic [31:0]              IOAddr        = 32'h30000,
    parameter int                       ROBWidth      = 4,
    parameter int                       InstTypeWidth = 6,
    parameter logic [InstTypeWidth-1:0] OpLB          = 6'd11,
    parameter logic [InstTypeWidth-1:0] OpLH          = 6'd12,
    parameter logic [InstTypeWidth-1:0] OpLW          = 6'd13,
    parameter logic [InstTypeWidth-1:0] OpLBU         = 6'd14,
    parameter logic [InstTypeWidth-1:0] OpLHU         = 6'd15
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     addrunit_lbuffer_en_in,
    input  logic [31:0]              addrunit_lbuffer_addr_in,
    input  logic [ROBWidth-1:0]      addrunit_lbuffer_dest_in,
    input  logic [InstTypeWidth-1:0] addrunit_lbuffer_opcode_in,
    output logic                     lbuffer_rs_rdy_out,
    input  logic                     rob_lbuffer_rst_in,
    input  logic [ROBWidth-1:0]      rob_lbuffer_head_in,
    input  logic                     rob_lbuffer_store_busy_in,
    output logic                     lbuffer_memctrl_en_out,
    output logic [31:0]              lbuffer_memctrl_addr_out,
    output logic [1:0]               lbuffer_memctrl_size_out,
    input  logic                     memctrl_lbuffer_valid_in,
    input  logic [31:0]              memctrl_lbuffer_data_in,
    output logic [ROBWidth-1:0]      cdb_lbuffer_b_out,
    output logic [31:0]              cdb_lbuffer_result_out
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t state_q, state_d;

    logic [31:0]              addr_mem [LBDepth];
    logic [ROBWidth-1:0]      dest_mem [LBDepth];
    logic [InstTypeWidth-1:0] op_mem   [LBDepth];

    logic [LBWidth-1:0] head, tail;
    logic [LBWidth:0]   count;
    logic               push, pop, issue, eligible;

    function automatic logic [1:0] access_size(input logic [InstTypeWidth-1:0] op);
        if (op == OpLB || op == OpLBU) return 2'd0;
        if (op == OpLH || op == OpLHU) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] extend_data(input logic [InstTypeWidth-1:0] op,
                                                input logic [31:0] raw);
        logic signed [7:0]  raw_b;
        logic signed [15:0] raw_h;
        raw_b = raw[7:0];
        raw_h = raw[15:0];
        if (op == OpLB)  return {{24{raw_b[7]}}, raw_b};
        if (op == OpLH)  return {{16{raw_h[15]}}, raw_h};
        if (op == OpLBU) return {24'd0, raw[7:0]};
        if (op == OpLHU) return {16'd0, raw[15:0]};
        return raw;
    endfunction

    // One slot is kept in reserve for the load already in flight in the address unit.
    assign lbuffer_rs_rdy_out = (int'(count) <= LBDepth - 2);

    assign push = addrunit_lbuffer_en_in && !rob_lbuffer_rst_in;

    always_comb begin
        eligible = (count != '0) && !rob_lbuffer_store_busy_in &&
                   ((addr_mem[head] < IOAddr) || (dest_mem[head] == rob_lbuffer_head_in));
        state_d  = state_q;
        issue    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE:    if (eligible) begin
                         issue   = 1'b1;
                         state_d = WAIT;
                     end
            WAIT:    if (memctrl_lbuffer_valid_in) begin
                         pop     = 1'b1;
                         state_d = IDLE;
                     end
            DRAIN:   if (memctrl_lbuffer_valid_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flushed in-flight read must still be absorbed before the next one can issue.
        if (rob_lbuffer_rst_in) begin
            issue = 1'b0;
            pop   = 1'b0;
            if (state_q == WAIT || state_q == DRAIN)
                state_d = memctrl_lbuffer_valid_in ? IDLE : DRAIN;
            else
                state_d = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)      state_q <= IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            addr_mem[tail] <= addrunit_lbuffer_addr_in;
            dest_mem[tail] <= addrunit_lbuffer_dest_in;
            op_mem[tail]   <= addrunit_lbuffer_opcode_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                     <= '0;
            tail                     <= '0;
            count                    <= '0;
            lbuffer_memctrl_en_out   <= 1'b0;
            lbuffer_memctrl_addr_out <= '0;
            lbuffer_memctrl_size_out <= '0;
            cdb_lbuffer_b_out        <= '0;
            cdb_lbuffer_result_out   <= '0;
        end else begin
            cdb_lbuffer_b_out <= '0;
            if (rdy_in) begin
                if (rob_lbuffer_rst_in) begin
                    head                   <= '0;
                    tail                   <= '0;
                    count                  <= '0;
                    lbuffer_memctrl_en_out <= 1'b0;
                end else begin
                    if (push) tail <= tail + 1'b1;
                    if (pop)  head <= head + 1'b1;
                    case ({push, pop})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: ;
                    endcase
                    if (issue) begin
                        lbuffer_memctrl_en_out   <= 1'b1;
                        lbuffer_memctrl_addr_out <= addr_mem[head];
                        lbuffer_memctrl_size_out <= access_size(op_mem[head]);
                    end else if (pop) begin
                        lbuffer_memctrl_en_out   <= 1'b0;
                    end
                    if (pop) begin
                        cdb_lbuffer_b_out      <= dest_mem[head];
                        cdb_lbuffer_result_out <= extend_data(op_mem[head], memctrl_lbuffer_data_in);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: queue-based reference model, per-cycle compare and directed scenarios.
module tb_load_buffer;

    localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        lb_en;
    logic [31:0] lb_addr;
    logic [3:0]  lb_dest;
    logic [5:0]  lb_op;
    logic        rs_rdy;
    logic        flush;
    logic [3:0]  rob_head;
    logic        store_busy;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [3:0]  cdb_b;
    logic [31:0] cdb_res;

    always #5 clk_in = ~clk_in;

    load_buffer dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .rdy_in                     (rdy_in),
        .addrunit_lbuffer_en_in     (lb_en),
        .addrunit_lbuffer_addr_in   (lb_addr),
        .addrunit_lbuffer_dest_in   (lb_dest),
        .addrunit_lbuffer_opcode_in (lb_op),
        .lbuffer_rs_rdy_out         (rs_rdy),
        .rob_lbuffer_rst_in         (flush),
        .rob_lbuffer_head_in        (rob_head),
        .rob_lbuffer_store_busy_in  (store_busy),
        .lbuffer_memctrl_en_out     (mem_en),
        .lbuffer_memctrl_addr_out   (mem_addr),
        .lbuffer_memctrl_size_out   (mem_size),
        .memctrl_lbuffer_valid_in   (mem_valid),
        .memctrl_lbuffer_data_in    (mem_data),
        .cdb_lbuffer_b_out          (cdb_b),
        .cdb_lbuffer_result_out     (cdb_res)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending loads plus whether a read is outstanding or being drained.
    typedef struct { logic [31:0] addr; logic [3:0] dest; logic [5:0] op; } ld_t;
    ld_t         mq[$];
    int          mode = 0;   // 0 no read, 1 read for head, 2 stale read
    logic        exp_en = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [1:0]  exp_size = '0;
    logic [3:0]  exp_b = '0;
    logic [31:0] exp_res = '0;

    function automatic logic [1:0] m_size(input logic [5:0] op);
        case (op)
            LB, LBU: return 2'd0;
            LH, LHU: return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] m_ext(input logic [5:0] op, input logic [31:0] d);
        int v;
        case (op)
            LB:      v = int'($signed(d[7:0]));
            LH:      v = int'($signed(d[15:0]));
            LBU:     v = int'(d & 32'h0000_00FF);
            LHU:     v = int'(d & 32'h0000_FFFF);
            default: v = int'(d);
        endcase
        return 32'(v);
    endfunction

    always @(posedge clk_in) begin
        exp_b = '0;
        if (rst_in) begin
            mq.delete();
            mode     = 0;
            exp_en   = 1'b0;
            exp_addr = '0;
            exp_size = '0;
            exp_res  = '0;
        end else if (rdy_in) begin
            if (flush) begin
                mq.delete();
                exp_en = 1'b0;
                if (mode != 0) mode = mem_valid ? 0 : 2;
            end else begin
                if (mode == 0 && mq.size() > 0 && !store_busy &&
                    (mq[0].addr < 32'h30000 || mq[0].dest == rob_head)) begin
                    mode     = 1;
                    exp_en   = 1'b1;
                    exp_addr = mq[0].addr;
                    exp_size = m_size(mq[0].op);
                end else if (mode == 1 && mem_valid) begin
                    exp_b   = mq[0].dest;
                    exp_res = m_ext(mq[0].op, mem_data);
                    void'(mq.pop_front());
                    exp_en  = 1'b0;
                    mode    = 0;
                end else if (mode == 2 && mem_valid) begin
                    mode = 0;
                end
                if (lb_en) begin
                    assert (mq.size() < 8) else $error("push into a full load buffer");
                    mq.push_back('{lb_addr, lb_dest, lb_op});
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            chk("mdl_en", 32'(mem_en), 32'(exp_en));
            chk("mdl_rs_rdy", 32'(rs_rdy), 32'(mq.size() <= 6));
            chk("mdl_b", 32'(cdb_b), 32'(exp_b));
            if (exp_en) begin
                chk("mdl_addr", mem_addr, exp_addr);
                chk("mdl_size", 32'(mem_size), 32'(exp_size));
            end
            if (exp_b != 0) chk("mdl_res", cdb_res, exp_res);
        end
    end

    // Broadcast recorder and request-length monitor.
    typedef struct { logic [3:0] tag; logic [31:0] val; } bc_t;
    bc_t bq[$];
    int  en_run = 0;
    int  last_run = 0;

    always @(negedge clk_in) begin
        if (cdb_b != 0) bq.push_back('{cdb_b, cdb_res});
        if (mem_en) en_run++;
        else if (en_run > 0) begin
            last_run = en_run;
            en_run   = 0;
        end
    end

    // Memory controller: one outstanding read, fixed latency, frozen while rdy_in is low.
    int          mem_lat = 1;
    logic [31:0] mem_img [logic [31:0]];
    bit          mbusy = 1'b0;
    int          mcnt = 0;
    logic [31:0] mpend = '0;

    always @(posedge clk_in) begin
        #1;
        mem_valid = 1'b0;
        if (rst_in) mbusy = 1'b0;
        else if (rdy_in) begin
            if (mbusy) begin
                if (mcnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = mpend;
                    mbusy     = 1'b0;
                end else mcnt--;
            end else if (mem_en) begin
                mbusy = 1'b1;
                mcnt  = mem_lat - 1;
                if (mem_img.exists(mem_addr)) mpend = mem_img[mem_addr];
                else mpend = {mem_addr[7:0] ^ 8'h9C, mem_addr[15:8] + 8'h81,
                              mem_addr[7:0] ^ 8'h3E, mem_addr[7:0] ^ 8'hF3};
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] d, input logic [5:0] op);
        lb_en   = 1'b1;
        lb_addr = a;
        lb_dest = d;
        lb_op   = op;
        @(negedge clk_in);
        lb_en = 1'b0;
    endtask

    task automatic wait_bq(input int n, input int maxc);
        int c = 0;
        while (bq.size() < n && c < maxc) begin
            @(negedge clk_in);
            c++;
        end
        chk("bcast_timeout", 32'(bq.size() >= n), 32'd1);
    endtask

    task automatic wait_en(input int maxc);
        int c = 0;
        while (!mem_en && c < maxc) begin
            @(negedge clk_in);
            c++;
        end
        chk("en_timeout", 32'(mem_en), 32'd1);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_size"}, 32'(mem_size), 32'd0);
        chk({tag, "_b"}, 32'(cdb_b), 32'd0);
        chk({tag, "_res"}, cdb_res, 32'd0);
        chk({tag, "_rs_rdy"}, 32'(rs_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [5];
        ops = '{LB, LH, LW, LBU, LHU};
        rst_in = 1'b1; rdy_in = 1'b1; lb_en = 1'b0; lb_addr = '0; lb_dest = '0; lb_op = '0;
        flush = 1'b0; rob_head = '0; store_busy = 1'b0; mem_valid = 1'b0; mem_data = '0;
        repeat (2) @(negedge clk_in);
        chk_on = 1'b1;
        reset_literals("rst");
        rst_in = 1'b0;
        idle(1);

        // Signed byte load, two-cycle request.
        mem_img[32'h100] = 32'h0000_00F0;
        push(32'h100, 4'd3, LB);
        wait_bq(1, 20);
        idle(2);
        chk("t1_tag", 32'(bq[0].tag), 32'd3);
        chk("t1_res", bq[0].val, 32'hFFFF_FFF0);
        chk("t1_en_len", 32'(last_run), 32'd2);

        // Two loads in order.
        bq.delete();
        mem_img[32'h200] = 32'h1234_ABCD;
        mem_img[32'h204] = 32'hDEAD_BEEF;
        push(32'h200, 4'd2, LHU);
        push(32'h204, 4'd5, LW);
        wait_bq(2, 30);
        idle(2);
        chk("t2_tag0", 32'(bq[0].tag), 32'd2);
        chk("t2_res0", bq[0].val, 32'h0000_ABCD);
        chk("t2_tag1", 32'(bq[1].tag), 32'd5);
        chk("t2_res1", bq[1].val, 32'hDEAD_BEEF);

        // Fill to 7 with a stalled memory.
        bq.delete();
        mem_lat = 40;
        for (int i = 0; i < 7; i++) begin
            push(32'h300 + 32'(4 * i), 4'(i + 1), LW);
            if (i == 5) chk("t3_rdy_at6", 32'(rs_rdy), 32'd1);
            if (i == 6) chk("t3_rdy_at7", 32'(rs_rdy), 32'd0);
        end
        mem_lat = 1;
        wait_bq(1, 60);
        chk("t3_rdy_after_pop", 32'(rs_rdy), 32'd1);
        wait_bq(7, 100);
        idle(2);
        for (int i = 0; i < 7; i++) chk("t3_order", 32'(bq[i].tag), 32'(i + 1));

        // Twenty back-to-back loads through wrapping pointers.
        bq.delete();
        for (int i = 0; i < 20; i++) begin
            int g = 0;
            while (!rs_rdy && g < 50) begin
                @(negedge clk_in);
                g++;
            end
            push(32'h1000 + 32'(4 * i), 4'((i % 15) + 1), ops[i % 5]);
        end
        wait_bq(20, 400);
        idle(2);
        for (int i = 0; i < 20; i++) chk("t3_wrap_order", 32'(bq[i].tag), 32'((i % 15) + 1));

        // I/O load waits for ROB head; store_busy blocks a normal load.
        bq.delete();
        rob_head = 4'd2;
        push(32'h30000, 4'd4, LW);
        idle(4);
        chk("t4_io_hold", 32'(mem_en), 32'd0);
        rob_head = 4'd4;
        @(negedge clk_in);
        chk("t4_io_go", 32'(mem_en), 32'd1);
        wait_bq(1, 20);
        idle(1);
        chk("t4_io_tag", 32'(bq[0].tag), 32'd4);
        mem_img[32'h500] = 32'h0000_8001;
        store_busy = 1'b1;
        push(32'h500, 4'd6, LH);
        idle(3);
        chk("t4_sb_hold", 32'(mem_en), 32'd0);
        store_busy = 1'b0;
        @(negedge clk_in);
        chk("t4_sb_go", 32'(mem_en), 32'd1);
        wait_bq(2, 20);
        idle(2);
        chk("t4_sb_tag", 32'(bq[1].tag), 32'd6);
        chk("t4_sb_res", bq[1].val, 32'hFFFF_8001);

        // Flush during a read; new load issues after the stale reply.
        bq.delete();
        mem_lat = 3;
        mem_img[32'h400] = 32'h0000_00FF;
        mem_img[32'h404] = 32'h0000_00A2;
        push(32'h400, 4'd7, LW);
        wait_en(20);
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        push(32'h404, 4'd8, LBU);
        wait_bq(1, 40);
        idle(3);
        chk("t5_count", 32'(bq.size()), 32'd1);
        chk("t5_tag", 32'(bq[0].tag), 32'd8);
        chk("t5_res", bq[0].val, 32'h0000_00A2);

        // Reset in the middle of a read.
        bq.delete();
        mem_lat = 10;
        push(32'h600, 4'd9, LW);
        wait_en(20);
        idle(1);
        rst_in = 1'b1;
        @(negedge clk_in);
        reset_literals("t6_rst");
        rst_in = 1'b0;
        idle(2);

        // rdy_in low while waiting for the reply.
        bq.delete();
        mem_lat = 6;
        mem_img[32'h700] = 32'h0000_807F;
        push(32'h700, 4'd10, LH);
        wait_en(20);
        rdy_in = 1'b0;
        idle(3);
        chk("t6_frz_en", 32'(mem_en), 32'd1);
        chk("t6_frz_b", 32'(cdb_b), 32'd0);
        rdy_in = 1'b1;
        wait_bq(1, 30);
        idle(3);
        chk("t6_count", 32'(bq.size()), 32'd1);
        chk("t6_tag", 32'(bq[0].tag), 32'd10);
        chk("t6_res", bq[0].val, 32'hFFFF_807F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- In-order FIFO of address-resolved loads between the address unit and the memory controller.
- Accepts a computed effective address, destination ROB tag and load opcode.
- Issues one memory read at a time, then sign- or zero-extends the returned data.
- Broadcasts the result on the load-buffer CDB lane, which is consumed by the reservation station and the ROB.
- Drives the load-buffer-ready signal the reservation station uses to gate load issue.

Parameters:
- LBDepth, 8: number of FIFO entries; power of two.
- LBWidth, 3: log2(LBDepth).
- IOAddr, 32'h30000: loads at or above this address are I/O and must be non-speculative.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: synchronous active-high reset.
- rdy_in, input, 1: global enable; when low, all state holds.
- addrunit_lbuffer_en_in, input, 1: push a load this cycle.
- addrunit_lbuffer_addr_in, input, 32: effective address.
- addrunit_lbuffer_dest_in, input, ROBWidth: destination ROB tag; never 0 when en is high.
- addrunit_lbuffer_opcode_in, input, InstTypeWidth: one of `LB/`LH/`LW/`LBU/`LHU.
- lbuffer_rs_rdy_out, input side of the RS, output here, 1: room for one more load.
- rob_lbuffer_rst_in, input, 1: misprediction flush.
- rob_lbuffer_head_in, input, ROBWidth: tag at the ROB head.
- rob_lbuffer_store_busy_in, input, 1: an uncommitted store older than any buffered load exists.
- lbuffer_memctrl_en_out, output, 1: read request valid.
- lbuffer_memctrl_addr_out, output, 32: read address.
- lbuffer_memctrl_size_out, output, 2: 0 = byte, 1 = half, 2 = word.
- memctrl_lbuffer_valid_in, input, 1: read data valid; one-cycle pulse.
- memctrl_lbuffer_data_in, input, 32: raw data, least-significant bytes first.
- cdb_lbuffer_b_out, output, ROBWidth: broadcast tag; 0 = no broadcast.
- cdb_lbuffer_result_out, output, 32: broadcast value.

Behaviour:
- Reset (rst_in=1 at posedge):
  - head = tail = count = 0; state = IDLE.
  - lbuffer_memctrl_en_out = 0, addr = 0, size = 0.
  - cdb_lbuffer_b_out = 0, result = 0.
  - lbuffer_rs_rdy_out = 1.
- rdy_in=0: all registers hold. cdb_lbuffer_b_out is still forced to 0, so no duplicate broadcast occurs.
- Push: on en_in, store {addr, dest, opcode} at tail; tail = tail+1 mod LBDepth; count+1. Pushing when count==LBDepth is a protocol violation; the bench asserts on it.
- lbuffer_rs_rdy_out: combinational, equal to (count <= LBDepth-2). The margin covers the one load in flight in the address unit.
- cdb_lbuffer_b_out is a one-cycle pulse, defaulting to 0 every cycle.
- States:
  - IDLE:
    - If count>0 and the head entry is eligible, drive en=1, addr and size from the head entry; go to WAIT.
    - Eligible means rob_lbuffer_store_busy_in==0, and also dest==rob_lbuffer_head_in when addr>=IOAddr.
    - A load pushed into an empty buffer is seen at the next cycle, so request en rises 1 cycle after the push at the earliest.
  - WAIT:
    - Hold en, addr and size stable until memctrl_lbuffer_valid_in.
    - On valid: en=0; pop the head; cdb_lbuffer_b_out=head dest next cycle; cdb_lbuffer_result_out=extended data; go to IDLE.
    - Extension: LB sign-extends data[7:0]; LH sign-extends data[15:0]; LBU and LHU zero-extend; LW passes through.
    - Minimum latency from push to CDB is 3 cycles with 1-cycle memory.
  - DRAIN:
    - Entered from WAIT on flush. en=0. Wait for valid, discard the data without broadcasting, then go to IDLE.
    - Pushes received while in DRAIN are accepted normally.
- Flush (rob_lbuffer_rst_in=1 with rdy_in=1):
  - head = tail = count = 0; cdb_lbuffer_b_out = 0.
  - Any push in the same cycle is dropped; the flush wins.
  - From IDLE: stay in IDLE, en=0.
  - From WAIT with valid not present that cycle: go to DRAIN.
  - From WAIT with valid present that cycle: data discarded, go to IDLE.
- Simultaneous push and pop in the same cycle: count is unchanged; both pointers advance.
- Pointers wrap modulo LBDepth; full vs empty is distinguished by count.
- Only one read is ever outstanding.

Test Plan:
- Push LB addr=0x100, dest=3; memory returns 0x000000F0 after 2 cycles → en held 2 cycles with size=0; then b=3, result=0xFFFFFFF0 for exactly one cycle.
- Push LHU dest=2 followed by LW dest=5; memory returns 0x1234ABCD then 0xDEADBEEF → b=2/result=0x0000ABCD, then b=5/result=0xDEADBEEF, in order, with en never overlapping.
- Push 7 loads with memory stalled → lbuffer_rs_rdy_out falls when count reaches 7; after one valid it rises again; wrap-around is exercised by 20 back-to-back loads all returning in FIFO order.
- Push LW addr=0x30000, dest=4 while rob_lbuffer_head_in=2 → no en; set head to 4 → en the next cycle. Also, store_busy=1 blocks issue of a normal load until it drops.
- Flush 1 cycle after en rises, with memory replying 3 cycles later → no CDB broadcast; a new load pushed during DRAIN issues only after the stale valid arrives and receives its own correct data.
- rst_in asserted mid-WAIT → all outputs return to reset values on the next cycle; rdy_in low during a valid hold-off freezes state with b=0.
